spatial_encoder_ctrl: RTL and testbench

Sequences the spatial accumulator over one frame of per-channel EMG features. Latches a frame from the feature front-end, then walks the channels one per cycle. For each channel it drives the item-memory index, the feature value, Enable and FirstHypervector. When the pass is complete it presents a valid/ready handshake to the temporal encoder, which samples the accumulator sign bits.

---
 rtl/spatial_encoder_ctrl.sv | 123 ++++++++++++
 tb/tb_spatial_encoder_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/spatial_encoder_ctrl.sv
// Spatial-encoder sequencer: latches one EMG frame and walks its channels into the accumulator.
// Optional build macro SPATIAL_SKIP_ZERO_EN skips zero-valued channels during the walk.
module spatial_encoder_ctrl #(
    parameter int NUM_CHANNELS  = 4,
    parameter int CHANNEL_WIDTH = 7,
    parameter int IDX_WIDTH     = 6
) (
    input  logic                                    Clk_CI,
    input  logic                                    Reset_RBI,
    input  logic                                    FrameValid_SI,
    output logic                                    FrameReady_SO,
    input  logic [NUM_CHANNELS*CHANNEL_WIDTH-1:0]   FrameIn_DI,
    output logic [IDX_WIDTH-1:0]                    ChannelIdx_DO,
    output logic [CHANNEL_WIDTH-1:0]                FeatureOut_DO,
    output logic                                    AccEnable_SO,
    output logic                                    AccFirst_SO,
    output logic                                    HvValid_SO,
    input  logic                                    HvReady_SI,
    output logic                                    Busy_SO
);

    localparam int FW = NUM_CHANNELS * CHANNEL_WIDTH;

    typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

    typedef struct packed {
        logic                 found;
        logic [IDX_WIDTH-1:0] idx;
    } pick_t;

    state_t          state_q;
    logic [FW-1:0]   frame_q;
    pick_t           acc_pick;
    pick_t           run_pick;
    logic            accept;

    function automatic logic [CHANNEL_WIDTH-1:0] feat_at(input logic [FW-1:0] f,
                                                         input logic [IDX_WIDTH-1:0] i);
        feat_at = '0;
        for (int unsigned k = 0; k < NUM_CHANNELS; k++) begin
            if (IDX_WIDTH'(k) == i) feat_at = f[k*CHANNEL_WIDTH +: CHANNEL_WIDTH];
        end
    endfunction

`ifdef SPATIAL_SKIP_ZERO_EN
    // Lowest channel at or above start with a nonzero feature; found=0 if none remain.
    function automatic pick_t next_ch(input logic [FW-1:0] f, input int unsigned start);
        pick_t p;
        p = '0;
        for (int unsigned k = NUM_CHANNELS; k > 0; k--) begin
            if ((k - 1) >= start && f[(k-1)*CHANNEL_WIDTH +: CHANNEL_WIDTH] != '0) begin
                p.found = 1'b1;
                p.idx   = IDX_WIDTH'(k - 1);
            end
        end
        return p;
    endfunction
`endif

    always_comb begin
`ifdef SPATIAL_SKIP_ZERO_EN
        acc_pick = next_ch(FrameIn_DI, 0);
        run_pick = next_ch(frame_q, 32'(ChannelIdx_DO) + 32'd1);
`else
        acc_pick.found = 1'b1;
        acc_pick.idx   = '0;
        run_pick.found = (ChannelIdx_DO != IDX_WIDTH'(NUM_CHANNELS - 1));
        run_pick.idx   = ChannelIdx_DO + 1'b1;
`endif
    end

    // DONE forwards HvReady so a waiting frame is taken on the same edge the HV is consumed.
    assign FrameReady_SO = (state_q == IDLE) || (state_q == DONE && HvReady_SI);
    assign accept        = FrameValid_SI && FrameReady_SO;

    always_ff @(posedge Clk_CI) begin
        if (!Reset_RBI) begin
            state_q       <= IDLE;
            frame_q       <= '0;
            ChannelIdx_DO <= '0;
            FeatureOut_DO <= '0;
            AccEnable_SO  <= 1'b0;
            AccFirst_SO   <= 1'b0;
            HvValid_SO    <= 1'b0;
            Busy_SO       <= 1'b0;
        end else if (accept) begin
            state_q       <= ACCUM;
            frame_q       <= FrameIn_DI;
            ChannelIdx_DO <= acc_pick.idx;
            FeatureOut_DO <= acc_pick.found ? feat_at(FrameIn_DI, acc_pick.idx) : '0;
            AccEnable_SO  <= 1'b1;
            AccFirst_SO   <= 1'b1;
            HvValid_SO    <= 1'b0;
            Busy_SO       <= 1'b1;
        end else begin
            case (state_q)
                ACCUM: begin
                    AccFirst_SO <= 1'b0;
                    if (run_pick.found) begin
                        ChannelIdx_DO <= run_pick.idx;
                        FeatureOut_DO <= feat_at(frame_q, run_pick.idx);
                    end else begin
                        state_q       <= DONE;
                        ChannelIdx_DO <= '0;
                        FeatureOut_DO <= '0;
                        AccEnable_SO  <= 1'b0;
                        HvValid_SO    <= 1'b1;
                    end
                end
                DONE: begin
                    if (HvReady_SI) begin
                        state_q    <= IDLE;
                        HvValid_SO <= 1'b0;
                        Busy_SO    <= 1'b0;
                    end
                end
                IDLE: ;
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spatial_encoder_ctrl.sv
// Scoreboard bench for spatial_encoder_ctrl: stimulus queues expected beats, a monitor checks them.
module tb_spatial_encoder_ctrl;

    localparam int NC = 4;
    localparam int CW = 7;
    localparam int IW = 6;

    logic              clk;
    logic              Reset_RBI;
    logic              FrameValid_SI;
    logic              FrameReady_SO;
    logic [NC*CW-1:0]  FrameIn_DI;
    logic [IW-1:0]     ChannelIdx_DO;
    logic [CW-1:0]     FeatureOut_DO;
    logic              AccEnable_SO;
    logic              AccFirst_SO;
    logic              HvValid_SO;
    logic              HvReady_SI;
    logic              Busy_SO;

    spatial_encoder_ctrl #(.NUM_CHANNELS(NC), .CHANNEL_WIDTH(CW), .IDX_WIDTH(IW)) dut (
        .Clk_CI(clk),
        .Reset_RBI(Reset_RBI),
        .FrameValid_SI(FrameValid_SI),
        .FrameReady_SO(FrameReady_SO),
        .FrameIn_DI(FrameIn_DI),
        .ChannelIdx_DO(ChannelIdx_DO),
        .FeatureOut_DO(FeatureOut_DO),
        .AccEnable_SO(AccEnable_SO),
        .AccFirst_SO(AccFirst_SO),
        .HvValid_SO(HvValid_SO),
        .HvReady_SI(HvReady_SI),
        .Busy_SO(Busy_SO)
    );

    typedef struct {
        int idx;
        int feat;
        int first;
    } beat_t;

    beat_t exp_q[$];
    int    len_q[$];
    int    first_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;
    int    run_len = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [NC*CW-1:0] mk(input int a, input int b, input int c, input int d);
        return {7'(d), 7'(c), 7'(b), 7'(a)};
    endfunction

    task automatic push_beat(input int idx, input int feat, input int first);
        beat_t b;
        b.idx = idx; b.feat = feat; b.first = first;
        exp_q.push_back(b);
    endtask

    // Expected beats for one full frame.
    task automatic push_frame(input int a, input int b, input int c, input int d);
        int v[4];
        int n;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        n = 0;
`ifdef SPATIAL_SKIP_ZERO_EN
        for (int k = 0; k < 4; k++) begin
            if (v[k] != 0) begin
                push_beat(k, v[k], (n == 0) ? 1 : 0);
                n++;
            end
        end
        if (n == 0) begin
            push_beat(0, 0, 1);
            n = 1;
        end
`else
        for (int k = 0; k < 4; k++) push_beat(k, v[k], (k == 0) ? 1 : 0);
        n = 4;
`endif
        len_q.push_back(n);
    endtask

    // Monitor: every enable cycle must match the next queued beat; each run length is checked.
    always @(negedge clk) begin
        if (AccEnable_SO) begin
            if (AccFirst_SO) first_q.push_back(cyc);
            if (exp_q.size() == 0) begin
                chk("unexpected_enable", 1, 0);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_idx",   int'(ChannelIdx_DO), e.idx);
                chk("beat_feat",  int'(FeatureOut_DO), e.feat);
                chk("beat_first", int'(AccFirst_SO),   e.first);
            end
            run_len++;
        end else if (run_len > 0) begin
            if (len_q.size() == 0) chk("unexpected_run", run_len, 0);
            else                   chk("run_len", run_len, len_q.pop_front());
            run_len = 0;
        end
    end

    // Present a frame and hold it until n handshakes complete; returns 1ns after the last accept edge.
    task automatic send(input logic [NC*CW-1:0] f, input int n);
        int acc;
        int waited;
        FrameValid_SI = 1'b1;
        FrameIn_DI    = f;
        acc = 0;
        waited = 0;
        while (acc < n && waited < 200) begin
            @(negedge clk);
            waited++;
            if (FrameValid_SI && FrameReady_SO) acc++;
        end
        if (acc < n) chk("accept_timeout", acc, n);
        @(posedge clk);
        #1;
        FrameValid_SI = 1'b0;
    endtask

    task automatic wait_hv(output int k);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!HvValid_SO && k < 40);
        if (!HvValid_SO) chk("hv_timeout", 0, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ready"}, int'(FrameReady_SO), 1);
        chk({tag, "_en"},    int'(AccEnable_SO),  0);
        chk({tag, "_first"}, int'(AccFirst_SO),   0);
        chk({tag, "_hv"},    int'(HvValid_SO),    0);
        chk({tag, "_idx"},   int'(ChannelIdx_DO), 0);
        chk({tag, "_feat"},  int'(FeatureOut_DO), 0);
        chk({tag, "_busy"},  int'(Busy_SO),       0);
    endtask

    initial begin
        int k;
        int w;
        Reset_RBI     = 1'b0;
        FrameValid_SI = 1'b0;
        FrameIn_DI    = '0;
        HvReady_SI    = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        Reset_RBI = 1'b1;

        // Basic frame with latency and handshake pulse.
        @(posedge clk); #1;
        push_frame(3, 5, 1, 7);
        send(mk(3, 5, 1, 7), 1);
        @(negedge clk);
        k = 1;
        chk("accum_busy",  int'(Busy_SO), 1);
        chk("accum_ready", int'(FrameReady_SO), 0);
        while (!HvValid_SO && k < 40) begin
            @(negedge clk);
            k++;
        end
        chk("hv_latency", k, 5);
        chk("done_busy", int'(Busy_SO), 1);
        @(negedge clk);
        chk("hv_one_cycle", int'(HvValid_SO), 0);
        chk("idle_busy",    int'(Busy_SO), 0);

        // Downstream stall: HV held, new frame refused.
        @(posedge clk); #1;
        HvReady_SI = 1'b0;
        push_frame(2, 6, 4, 0);
        send(mk(2, 6, 4, 0), 1);
        wait_hv(k);
        @(posedge clk); #1;
        FrameValid_SI = 1'b1;
        FrameIn_DI    = mk(9, 9, 9, 9);
        repeat (10) begin
            @(negedge clk);
            chk("stall_hv",    int'(HvValid_SO), 1);
            chk("stall_ready", int'(FrameReady_SO), 0);
            chk("stall_en",    int'(AccEnable_SO), 0);
        end

        // Back-to-back frames straight out of DONE.
        @(posedge clk); #1;
        HvReady_SI = 1'b1;
        first_q.delete();
        repeat (3) push_frame(1, 1, 1, 1);
        send(mk(1, 1, 1, 1), 3);
        wait_hv(k);
        chk("b2b_frames", first_q.size(), 3);
        if (first_q.size() == 3) begin
            chk("b2b_period1", first_q[1] - first_q[0], 5);
            chk("b2b_period2", first_q[2] - first_q[1], 5);
        end

        // Reset during the second ACCUM cycle.
        @(posedge clk); #1;
        push_beat(0, 4, 1);
        push_beat(1, 3, 0);
        len_q.push_back(2);
        send(mk(4, 3, 2, 1), 1);
        @(posedge clk); #1;
        Reset_RBI = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk_reset_vals("midreset");
        Reset_RBI = 1'b1;
        @(posedge clk); #1;
        push_frame(5, 6, 7, 8);
        send(mk(5, 6, 7, 8), 1);
        wait_hv(k);

        // FrameValid toggled with other data while accumulating.
        @(posedge clk); #1;
        push_frame(10, 20, 30, 40);
        send(mk(10, 20, 30, 40), 1);
        FrameValid_SI = 1'b1;
        FrameIn_DI    = mk(99, 98, 97, 96);
        @(posedge clk); #1;
        FrameValid_SI = 1'b0;
        @(posedge clk); #1;
        FrameValid_SI = 1'b1;
        @(posedge clk); #1;
        FrameValid_SI = 1'b0;
        wait_hv(k);

        // Frames with zero features.
        @(posedge clk); #1;
        push_frame(0, 4, 0, 2);
        send(mk(0, 4, 0, 2), 1);
        wait_hv(k);
        @(posedge clk); #1;
        push_frame(0, 0, 0, 0);
        send(mk(0, 0, 0, 0), 1);
        wait_hv(k);

        w = 0;
        while ((exp_q.size() != 0 || len_q.size() != 0) && w < 20) begin
            @(negedge clk);
            w++;
        end
        repeat (2) @(negedge clk);
        chk("leftover_beats", exp_q.size(), 0);
        chk("leftover_runs",  len_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
